// File: rtl/variance_normalizer.sv
// rtl/variance_normalizer.sv - window variance N*sum(x^2) - (sum x)^2 with optional integer sqrt (VARNORM_STDDEV_EN)
module variance_normalizer #(
    parameter int SUM_W    = 32,
    parameter int SQ_W     = 48,
    parameter int WIN_BITS = 6,
    parameter int VAR_W    = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [WIN_BITS-1:0]   win_size,
    output logic                  ready,
    output logic [1:0]            rd_addr,
    input  logic [SUM_W-1:0]      rd_data,
    input  logic [SQ_W-1:0]       rd_data_sq,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VAR_W-1:0]      var_out,
    output logic [VAR_W/2-1:0]    std_out
);

    localparam int NW    = 2 * WIN_BITS;
    localparam int SA_W  = SUM_W + 2;
    localparam int QA_W  = SQ_W + 2;
    localparam int P1F_W = NW + 1 + QA_W;
    localparam int P2F_W = 2 * SA_W;
    localparam int PMAXW = (P1F_W > P2F_W) ? P1F_W : P2F_W;
    localparam int WIDE  = ((PMAXW > VAR_W + 1) ? PMAXW : VAR_W + 1) + 1;
    localparam logic signed [WIDE-1:0] P_HI = {{(WIDE-VAR_W){1'b0}}, {VAR_W{1'b1}}};
    localparam logic signed [WIDE-1:0] P_LO = {{(WIDE-VAR_W){1'b1}}, {VAR_W{1'b0}}};

    typedef enum logic [3:0] {
        S_RESET, S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3,
        S_WAIT, S_MULT, S_SUB, S_SQRT, S_HOLD
    } state_t;

    state_t                   r_state;
    logic                     r_ready;
    logic [1:0]               r_rd_addr;
    logic                     r_out_valid;
    logic [VAR_W-1:0]         r_var_out;
    logic [NW-1:0]            r_n;
    logic signed [SA_W-1:0]   r_sum_acc;
    logic signed [QA_W-1:0]   r_sq_acc;
    logic signed [VAR_W:0]    r_p1;
    logic signed [VAR_W:0]    r_p2;

    logic [WIN_BITS-1:0]      w_ws_m2;
    logic [NW-1:0]            w_n;
    logic signed [SA_W-1:0]   w_sum_in;
    logic signed [QA_W-1:0]   w_sq_in;
    logic signed [WIDE-1:0]   w_p1_full;
    logic signed [WIDE-1:0]   w_p2_full;
    logic signed [VAR_W:0]    w_p1;
    logic signed [VAR_W:0]    w_p2;
    logic signed [VAR_W+1:0]  w_diff;
    logic [VAR_W-1:0]         w_var;

    assign w_ws_m2  = win_size - WIN_BITS'(2);
    assign w_n      = (win_size >= WIN_BITS'(3)) ? NW'(w_ws_m2) * NW'(w_ws_m2) : '0;
    assign w_sum_in = $signed({2'b00, rd_data});
    assign w_sq_in  = $signed({2'b00, rd_data_sq});

    // Products are formed full-width, then pinned into the VAR_W+1 signed registers.
    assign w_p1_full = WIDE'($signed({1'b0, r_n})) * WIDE'(r_sq_acc);
    assign w_p2_full = WIDE'(r_sum_acc) * WIDE'(r_sum_acc);
    assign w_p1 = (w_p1_full > P_HI) ? P_HI[VAR_W:0] :
                  (w_p1_full < P_LO) ? P_LO[VAR_W:0] : w_p1_full[VAR_W:0];
    assign w_p2 = (w_p2_full > P_HI) ? P_HI[VAR_W:0] :
                  (w_p2_full < P_LO) ? P_LO[VAR_W:0] : w_p2_full[VAR_W:0];
    assign w_diff = (VAR_W+2)'(r_p1) - (VAR_W+2)'(r_p2);

    always_comb begin
        w_var = w_diff[VAR_W-1:0];
        if (w_diff[VAR_W+1]) begin
            w_var = '0;
        end else if (w_diff[VAR_W]) begin
            w_var = '1;
        end
    end

`ifdef VARNORM_STDDEV_EN
    localparam int H  = VAR_W / 2;
    localparam int CW = $clog2(H);

    logic [H:0]       r_rem;
    logic [H-1:0]     r_root;
    logic [H-1:0]     r_std_out;
    logic [VAR_W-1:0] r_sq_x;
    logic [CW-1:0]    r_sq_cnt;
    logic [H+2:0]     w_rem_sh;
    logic [H+2:0]     w_trial;
    logic [H+2:0]     w_rem_nx;
    logic             w_ge;
    logic [H-1:0]     w_root_nx;
    logic             w_unused_rem_hi;

    // Restoring square root: two radicand bits in, one root bit out per cycle.
    assign w_rem_sh        = {r_rem, r_sq_x[VAR_W-1:VAR_W-2]};
    assign w_trial         = {1'b0, r_root, 2'b01};
    assign w_ge            = (w_rem_sh >= w_trial);
    assign w_rem_nx        = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nx       = {r_root[H-2:0], w_ge};
    assign w_unused_rem_hi = ^w_rem_nx[H+2:H+1];
    assign std_out         = r_std_out;
`else
    assign std_out = '0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_RESET;
            r_ready     <= 1'b0;
            r_rd_addr   <= 2'd0;
            r_out_valid <= 1'b0;
            r_var_out   <= '0;
            r_n         <= '0;
            r_sum_acc   <= '0;
            r_sq_acc    <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
`ifdef VARNORM_STDDEV_EN
            r_rem       <= '0;
            r_root      <= '0;
            r_std_out   <= '0;
            r_sq_x      <= '0;
            r_sq_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RD0;
                        r_ready   <= 1'b0;
                        r_n       <= w_n;
                        r_sum_acc <= '0;
                        r_sq_acc  <= '0;
                        r_rd_addr <= 2'd0;
                    end
                end
                S_RD0: begin
                    r_rd_addr <= 2'd1;
                    r_state   <= S_RD1;
                end
                // Read data lags the address by one cycle: corner A lands here.
                S_RD1: begin
                    r_sum_acc <= r_sum_acc + w_sum_in;
                    r_sq_acc  <= r_sq_acc + w_sq_in;
                    r_rd_addr <= 2'd2;
                    r_state   <= S_RD2;
                end
                S_RD2: begin
                    r_sum_acc <= r_sum_acc - w_sum_in;
                    r_sq_acc  <= r_sq_acc - w_sq_in;
                    r_rd_addr <= 2'd3;
                    r_state   <= S_RD3;
                end
                S_RD3: begin
                    r_sum_acc <= r_sum_acc - w_sum_in;
                    r_sq_acc  <= r_sq_acc - w_sq_in;
                    r_rd_addr <= 2'd0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    r_sum_acc <= r_sum_acc + w_sum_in;
                    r_sq_acc  <= r_sq_acc + w_sq_in;
                    r_state   <= S_MULT;
                end
                S_MULT: begin
                    r_p1    <= w_p1;
                    r_p2    <= w_p2;
                    r_state <= S_SUB;
                end
                S_SUB: begin
                    r_var_out <= w_var;
`ifdef VARNORM_STDDEV_EN
                    r_sq_x   <= w_var;
                    r_rem    <= '0;
                    r_root   <= '0;
                    r_sq_cnt <= '0;
                    r_state  <= S_SQRT;
`else
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
`endif
                end
`ifdef VARNORM_STDDEV_EN
                S_SQRT: begin
                    r_rem    <= w_rem_nx[H:0];
                    r_root   <= w_root_nx;
                    r_sq_x   <= {r_sq_x[VAR_W-3:0], 2'b00};
                    r_sq_cnt <= r_sq_cnt + 1'b1;
                    if (r_sq_cnt == CW'(H - 1)) begin
                        r_std_out   <= w_root_nx;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
`endif
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_ready     <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_RESET;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign rd_addr   = r_rd_addr;
    assign out_valid = r_out_valid;
    assign var_out   = r_var_out;

endmodule

// File: doc/variance_normalizer.md
# variance_normalizer

Per-core stage directly downstream of the processor loader's variance-cache writes. Once the loader reports the variance constants loaded, it reads the four integral and four squared-integral corner samples for one detection window from the core's variance cache. It then computes the window's unnormalised variance N·Σx² − (Σx)² and, optionally, its integer standard deviation. The result is presented to the classifier through a valid/ready handshake.

## Interface
- `SUM_W`, default 32: width of integral-image corner samples.
- `SQ_W`, default 48: width of squared-integral corner samples.
- `WIN_BITS`, default 6: width of `win_size`.
- `VAR_W`, default 64: width of `var_out`. Must be even and ≥ 2·SUM_W.
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin one computation. Sampled only in IDLE.
- `win_size`, in, WIN_BITS: window edge length. Sampled with `start`.
- `ready`, out, 1: high in IDLE.
- `rd_addr`, out, 2: variance-cache read address. 0=A, 1=B, 2=C, 3=D.
- `rd_data`, in, SUM_W: integral read data, one cycle after `rd_addr`.
- `rd_data_sq`, in, SQ_W: squared-integral read data, one cycle after `rd_addr`.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `var_out`, out, VAR_W: unnormalised variance.
- `std_out`, out, VAR_W/2: integer standard deviation. Driven 0 when the feature is compiled out.

## Operation
- States: RESET → IDLE → RD0 → RD1 → RD2 → RD3 → WAIT → MULT → SUB → [SQRT] → HOLD → IDLE.
- RESET lasts one cycle after `resetn` deasserts, then the FSM moves to IDLE.
- IDLE with `start`=1:
  - latch `win_size`;
  - clear both accumulators;
  - compute N = (win_size−2)² if win_size ≥ 3, else N = 0.
- RDk drives `rd_addr`=k. Data returned for address k is accumulated one cycle later.
  - Sign is + for A and D, − for B and C.
  - Sum accumulator is SUM_W+2 bits signed; square accumulator is SQ_W+2 bits signed.
- WAIT accumulates D.
- MULT registers P1 = N·sq_acc and P2 = sum_acc·sum_acc, each VAR_W+1 bits signed.
- SUB computes var = P1 − P2.
  - Negative results clamp to 0.
  - Values above 2^VAR_W−1 saturate to 2^VAR_W−1.
- SQRT runs one result bit per cycle, restoring method: VAR_W/2 cycles, floor(√var).
- HOLD asserts `out_valid`. `var_out` and `std_out` stay stable until `out_ready`=1. The FSM returns to IDLE on the cycle after acceptance.
- `start` outside IDLE is ignored; it is not queued.
- `resetn`=0 in any state returns the FSM to RESET on the next edge and aborts the computation. No result is emitted.

## Timing
- Reset values:
  - `ready`=0 in RESET, 1 in IDLE.
  - `rd_addr`=0, `out_valid`=0, `var_out`=0, `std_out`=0.
- `start` seen in IDLE at cycle 0: RD0 runs in cycle 1, RD3 in cycle 4, WAIT in cycle 5, MULT in cycle 6, SUB in cycle 7.
- `out_valid` first asserts in cycle 8 with the feature compiled out, or cycle 8+VAR_W/2 (cycle 40 at defaults) with it compiled in.
- `out_valid` and `out_ready` both high in cycle T: `ready`=1 in cycle T+1, and a new `start` is accepted in T+1.
- Minimum throughput is one result per 9 cycles without the feature, or per 41 cycles with it at defaults.
- `rd_addr` holds 0 outside the RD states. The cache tolerates idle reads.

## Configuration
- `VARNORM_STDDEV_EN` defined:
  - SQRT state and iterative square-root datapath are built;
  - `std_out` = floor(√var_out);
  - latency grows by VAR_W/2 cycles.
- `VARNORM_STDDEV_EN` undefined:
  - no SQRT state; SUB goes directly to HOLD;
  - `std_out` is tied to 0;
  - no square-root logic is synthesised.

## Test plan
- Uniform window: win_size=24 (N=484), sum corners A=B=C=0, D=4840, squared corners A'=B'=C'=0, D'=48400. Expect `var_out`=0 and `std_out`=0.
- Mixed corners: win_size=24, A=100, B=200, C=300, D=1000 (sum 600); A'=1000, B'=2000, C'=3000, D'=50000 (Σx²=46000). Expect `var_out`=21904000 and, with the feature compiled in, `std_out`=4680. `out_valid` must rise in cycle 8 (feature out) or cycle 40 (feature in).
- Negative clamp: win_size=24, D=1000, D'=1, all other corners 0. Expect `var_out`=0. Also win_size=2 (N=0) with D=5 gives `var_out`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises. Outputs must stay stable throughout, `ready` stays 0, and a `start` pulse in that window is ignored. Release `out_ready`; expect `ready`=1 on the next cycle.
- Back-to-back: issue `start` in the cycle after acceptance with new corners. Expect a second correct result with no lost or duplicated `out_valid`.
- Reset mid-operation: assert `resetn`=0 during MULT. Expect no `out_valid`, all outputs at reset values, and `ready`=1 two cycles after `resetn` returns to 1.
